// File: rtl/mem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_arbiter_pkg
//   Shared encodings for the instruction/data memory arbiter.
//   - state_t : arbiter FSM state (IDLE / ISSUE / WAIT)
//   - gnt_t   : which requester owns the memory port (GNT_I / GNT_D)
//   - kind_t  : access kind held in a pending slot (RD / WR)
// -----------------------------------------------------------------------------
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    typedef enum logic {
        GNT_I = 1'b0,
        GNT_D = 1'b1
    } gnt_t;

    typedef enum logic {
        RD = 1'b0,
        WR = 1'b1
    } kind_t;

endpackage

// File: rtl/mem_req_slot.sv
// -----------------------------------------------------------------------------
// mem_req_slot
//   Holds one pending memory request for a single requester.
//
//   Ports:
//     clk, rst             clock, asynchronous active-low reset
//     rstrb, wstrb         requester strobes; wstrb wins when both are high
//     addr, wdata, wmask   request payload, captured on an accepted strobe
//     clear                owner's access completed; empties the slot
//     valid, kind          registered slot occupancy and access kind
//     peek_*               the request as the arbiter should see it this
//                          cycle: the stored one if occupied, otherwise the
//                          one being strobed in right now
// -----------------------------------------------------------------------------
module mem_req_slot
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int MASK_W = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rstrb,
    input  logic              wstrb,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [MASK_W-1:0] wmask,
    input  logic              clear,
    output logic              valid,
    output kind_t             kind,
    output logic              peek_valid,
    output logic [ADDR_W-1:0] peek_addr,
    output logic [DATA_W-1:0] peek_wdata,
    output logic [MASK_W-1:0] peek_wmask,
    output kind_t             peek_kind
);

    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [MASK_W-1:0] wmask_q;
    logic              load;

    // A strobe while the slot is occupied is a protocol violation and is dropped.
    assign load = (rstrb || wstrb) && !valid;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of block evaluation order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid   <= 1'b0;
            kind    <= RD;
            addr_q  <= '0;
            wdata_q <= '0;
            wmask_q <= '0;
        end else if (load) begin
            valid   <= 1'b1;
            kind    <= wstrb ? WR : RD;
            addr_q  <= addr;
            wdata_q <= wdata;
            wmask_q <= wmask;
        end else if (clear) begin
            valid   <= 1'b0;
        end
    end

    // NOTE: every output gets a value on every path; without the defaults an
    // unassigned path would infer a latch.
    always_comb begin
        peek_valid = valid || load;
        peek_addr  = addr_q;
        peek_wdata = wdata_q;
        peek_wmask = wmask_q;
        peek_kind  = kind;
        if (!valid) begin
            peek_addr  = addr;
            peek_wdata = wdata;
            peek_wmask = wmask;
            peek_kind  = wstrb ? WR : RD;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//   Shares one single-port memory between the instruction fetch port
//   (read-only) and the data port (read/write). Each requester has a one-deep
//   pending slot; accesses are serialised onto the memory port with
//   alternating priority on ties (D first after reset).
//
//   Ports:
//     clk, rst                       clock, asynchronous active-low reset
//     i_addr, i_rstrb                fetch request
//     i_rdata, i_rbusy               fetch data / fetch in progress
//     d_addr, d_wdata, d_wmask       data request payload
//     d_wstrb, d_rstrb               store / load strobes (store wins if both)
//     d_rdata, d_rbusy, d_wbusy      load data / load busy / store busy
//     m_addr, m_wdata, m_wmask       memory request payload (0 when idle)
//     m_rstrb, m_wstrb               memory strobes, high only in ISSUE
//     m_rdata, m_rbusy, m_wbusy      memory response
// -----------------------------------------------------------------------------
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ADDR_W-1:0]   i_addr,
    input  logic                i_rstrb,
    output logic [DATA_W-1:0]   i_rdata,
    output logic                i_rbusy,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_wmask,
    input  logic                d_wstrb,
    input  logic                d_rstrb,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                d_rbusy,
    output logic                d_wbusy,
    output logic [ADDR_W-1:0]   m_addr,
    output logic [DATA_W-1:0]   m_wdata,
    output logic [DATA_W/8-1:0] m_wmask,
    output logic                m_rstrb,
    output logic                m_wstrb,
    input  logic [DATA_W-1:0]   m_rdata,
    input  logic                m_rbusy,
    input  logic                m_wbusy
);

    localparam int MASK_W = DATA_W / 8;

    state_t            state;
    gnt_t              gnt;
    gnt_t              last_gnt;
    kind_t             cur_kind;
    logic [DATA_W-1:0] i_rdata_q;
    logic [DATA_W-1:0] d_rdata_q;

    logic              i_valid, d_valid;
    kind_t             i_kind, d_kind;
    logic              i_pv, d_pv;
    logic [ADDR_W-1:0] i_paddr, d_paddr;
    logic [DATA_W-1:0] i_pwdata, d_pwdata;
    logic [MASK_W-1:0] i_pwmask, d_pwmask;
    kind_t             i_pkind, d_pkind;

    logic              mem_done;
    logic              i_fin, d_fin;
    logic              sel_d;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic [MASK_W-1:0] sel_wmask;
    kind_t             sel_kind;

    mem_req_slot #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MASK_W(MASK_W)) u_i_slot (
        .clk        (clk),
        .rst        (rst),
        .rstrb      (i_rstrb),
        .wstrb      (1'b0),
        .addr       (i_addr),
        .wdata      ('0),
        .wmask      ('0),
        .clear      (i_fin),
        .valid      (i_valid),
        .kind       (i_kind),
        .peek_valid (i_pv),
        .peek_addr  (i_paddr),
        .peek_wdata (i_pwdata),
        .peek_wmask (i_pwmask),
        .peek_kind  (i_pkind)
    );

    mem_req_slot #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MASK_W(MASK_W)) u_d_slot (
        .clk        (clk),
        .rst        (rst),
        .rstrb      (d_rstrb),
        .wstrb      (d_wstrb),
        .addr       (d_addr),
        .wdata      (d_wdata),
        .wmask      (d_wmask),
        .clear      (d_fin),
        .valid      (d_valid),
        .kind       (d_kind),
        .peek_valid (d_pv),
        .peek_addr  (d_paddr),
        .peek_wdata (d_pwdata),
        .peek_wmask (d_pwmask),
        .peek_kind  (d_pkind)
    );

    // Completion: first WAIT cycle in which the busy matching the access is low.
    assign mem_done = (cur_kind == RD) ? !m_rbusy : !m_wbusy;
    assign i_fin    = (state == WAIT) && mem_done && (gnt == GNT_I);
    assign d_fin    = (state == WAIT) && mem_done && (gnt == GNT_D);

    // Tie-break alternates: D wins unless D owned the last completed access.
    assign sel_d = d_pv && (!i_pv || (last_gnt == GNT_I));

    always_comb begin
        sel_addr  = i_paddr;
        sel_wdata = i_pwdata;
        sel_wmask = i_pwmask;
        sel_kind  = i_pkind;
        if (sel_d) begin
            sel_addr  = d_paddr;
            sel_wdata = d_pwdata;
            sel_wmask = d_pwmask;
            sel_kind  = d_pkind;
        end
    end

    // Arbitration in IDLE uses the peek view, so a strobe arriving in an idle
    // cycle reaches the memory on the very next cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            gnt       <= GNT_I;
            last_gnt  <= GNT_I;
            cur_kind  <= RD;
            m_addr    <= '0;
            m_wdata   <= '0;
            m_wmask   <= '0;
            m_rstrb   <= 1'b0;
            m_wstrb   <= 1'b0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_pv || d_pv) begin
                        state    <= ISSUE;
                        gnt      <= sel_d ? GNT_D : GNT_I;
                        cur_kind <= sel_kind;
                        m_addr   <= sel_addr;
                        m_wdata  <= sel_wdata;
                        m_wmask  <= sel_wmask;
                        m_rstrb  <= (sel_kind == RD);
                        m_wstrb  <= (sel_kind == WR);
                    end
                end
                ISSUE: begin
                    state   <= WAIT;
                    m_rstrb <= 1'b0;
                    m_wstrb <= 1'b0;
                end
                WAIT: begin
                    if (mem_done) begin
                        state    <= IDLE;
                        last_gnt <= gnt;
                        m_addr   <= '0;
                        m_wdata  <= '0;
                        m_wmask  <= '0;
                        if (cur_kind == RD) begin
                            if (gnt == GNT_I) i_rdata_q <= m_rdata;
                            else              d_rdata_q <= m_rdata;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Read data is forwarded in the completion cycle (when busy drops) and
    // held in the per-port register afterwards.
    assign i_rdata = (i_fin && cur_kind == RD) ? m_rdata : i_rdata_q;
    assign d_rdata = (d_fin && cur_kind == RD) ? m_rdata : d_rdata_q;

    assign i_rbusy = i_valid && (i_kind == RD) && !i_fin;
    assign d_rbusy = d_valid && (d_kind == RD) && !d_fin;
    assign d_wbusy = d_valid && (d_kind == WR) && !d_fin;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] i_addr = '0;
    logic        i_rstrb = 1'b0;
    logic [31:0] i_rdata;
    logic        i_rbusy;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic [3:0]  d_wmask = '0;
    logic        d_wstrb = 1'b0;
    logic        d_rstrb = 1'b0;
    logic [31:0] d_rdata;
    logic        d_rbusy;
    logic        d_wbusy;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [3:0]  m_wmask;
    logic        m_rstrb;
    logic        m_wstrb;
    logic [31:0] m_rdata;
    logic        m_rbusy;
    logic        m_wbusy;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk     (clk),
        .rst     (rst),
        .i_addr  (i_addr),
        .i_rstrb (i_rstrb),
        .i_rdata (i_rdata),
        .i_rbusy (i_rbusy),
        .d_addr  (d_addr),
        .d_wdata (d_wdata),
        .d_wmask (d_wmask),
        .d_wstrb (d_wstrb),
        .d_rstrb (d_rstrb),
        .d_rdata (d_rdata),
        .d_rbusy (d_rbusy),
        .d_wbusy (d_wbusy),
        .m_addr  (m_addr),
        .m_wdata (m_wdata),
        .m_wmask (m_wmask),
        .m_rstrb (m_rstrb),
        .m_wstrb (m_wstrb),
        .m_rdata (m_rdata),
        .m_rbusy (m_rbusy),
        .m_wbusy (m_wbusy)
    );

    // ------------------------------------------------------------------ memory
    logic [31:0] mem [0:255];
    bit          mem_loaded = 1'b0;
    int          fixed_stall = 0;
    bit          rand_stall = 1'b0;
    int          r_left = 0;
    int          w_left = 0;
    logic [31:0] r_addr = '0;

    function automatic logic [31:0] init_word(input int idx);
        if (idx == 4) return 32'h0000_0013;
        return {16'hA5A5, 8'(idx), 8'(idx)};
    endfunction

    function automatic int pick_stall();
        if (rand_stall) return int'($urandom_range(0, 3));
        return fixed_stall;
    endfunction

    // Contents survive later resets; only the handshake state is reset.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_left <= 0;
            w_left <= 0;
            r_addr <= '0;
            if (!mem_loaded) begin
                for (int k = 0; k < 256; k++) mem[k] <= init_word(k);
                mem_loaded <= 1'b1;
            end
        end else begin
            if (m_rstrb) begin
                r_left <= pick_stall();
                r_addr <= m_addr;
            end else if (r_left != 0) begin
                r_left <= r_left - 1;
            end
            if (m_wstrb) begin
                w_left <= pick_stall();
                for (int b = 0; b < 4; b++)
                    if (m_wmask[b]) mem[m_addr[9:2]][8*b +: 8] <= m_wdata[8*b +: 8];
            end else if (w_left != 0) begin
                w_left <= w_left - 1;
            end
        end
    end

    assign m_rbusy = (r_left != 0);
    assign m_wbusy = (w_left != 0);
    assign m_rdata = mem[r_addr[9:2]];

    // ------------------------------------------------------- strobe monitor
    typedef struct {
        int          cyc;
        logic [31:0] addr;
    } strobe_t;

    strobe_t mon_q[$];
    int      cyc_cnt = 0;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;
    always @(negedge clk) if (m_rstrb || m_wstrb) mon_q.push_back('{cyc_cnt, m_addr});

    // ---------------------------------------------------------------- checks
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_m_addr"},  m_addr, 32'h0);
        check({tag, "_m_wdata"}, m_wdata, 32'h0);
        check({tag, "_m_ctl"},   {27'h0, m_wmask, m_rstrb}, 32'h0);
        check({tag, "_m_wstrb"}, {31'h0, m_wstrb}, 32'h0);
        check({tag, "_busy"},    {29'h0, i_rbusy, d_rbusy, d_wbusy}, 32'h0);
        check({tag, "_i_rdata"}, i_rdata, 32'h0);
        check({tag, "_d_rdata"}, d_rdata, 32'h0);
    endtask

    function automatic logic port_busy(input bit port_d, input bit wr);
        if (!port_d) return i_rbusy;
        return wr ? d_wbusy : d_rbusy;
    endfunction

    // One access from one port: strobe for a cycle, then poll the port's busy
    // (bounded). lat = cycles from the strobe cycle to the completion cycle.
    task automatic do_access(input bit port_d, input bit wr, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [3:0] wmask,
                             input bit detailed, output logic [31:0] rdata, output int lat);
        @(posedge clk); #1;
        if (port_d) begin
            d_addr  = addr;
            d_wdata = wdata;
            d_wmask = wmask;
            d_wstrb = wr;
            d_rstrb = !wr;
        end else begin
            i_addr  = addr;
            i_rstrb = 1'b1;
        end
        @(posedge clk); #1;
        if (port_d) begin
            d_wstrb = 1'b0;
            d_rstrb = 1'b0;
        end else begin
            i_rstrb = 1'b0;
        end
        lat = 1;
        check("busy_rise", {31'h0, port_busy(port_d, wr)}, 32'h1);
        if (detailed) begin
            check("issue_addr", m_addr, addr);
            check("issue_strb", {30'h0, m_wstrb, m_rstrb}, {30'h0, wr, !wr});
            if (wr) check("issue_wdata", m_wdata, wdata);
            if (wr) check("issue_wmask", {28'h0, m_wmask}, {28'h0, wmask});
            if (port_d) check("other_busy", {31'h0, wr ? d_rbusy : d_wbusy}, 32'h0);
        end
        while (port_busy(port_d, wr) && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        check("done_in_time", {31'h0, port_busy(port_d, wr)}, 32'h0);
        rdata = port_d ? d_rdata : i_rdata;
    endtask

    task automatic do_reset();
        @(negedge clk) rst = 1'b0;
        @(negedge clk);
        @(negedge clk) rst = 1'b1;
    endtask

    // ----------------------------------------------------------------- vectors
    typedef struct {
        bit          port_d;
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wmask;
        int          stall;
        logic [31:0] exp_rdata;
        int          exp_lat;
    } vec_t;

    vec_t        vecs[8];
    logic [31:0] dmodel[64:127];

    initial begin : main
        logic [31:0] rd;
        int          lat;
        int          base;

        vecs[0] = '{1'b0, 1'b0, 32'h10, 32'h0,        4'h0, 0, 32'h0000_0013, 2};
        vecs[1] = '{1'b1, 1'b1, 32'h40, 32'hDEADBEEF, 4'hF, 0, 32'h0,         2};
        vecs[2] = '{1'b1, 1'b0, 32'h40, 32'h0,        4'h0, 0, 32'hDEADBEEF,  2};
        vecs[3] = '{1'b1, 1'b1, 32'h40, 32'h0000CAFE, 4'h3, 0, 32'h0,         2};
        vecs[4] = '{1'b1, 1'b0, 32'h40, 32'h0,        4'h0, 0, 32'hDEADCAFE,  2};
        vecs[5] = '{1'b1, 1'b1, 32'h44, 32'h12345678, 4'hA, 2, 32'h0,         4};
        vecs[6] = '{1'b1, 1'b0, 32'h44, 32'h0,        4'h0, 1, 32'h12A55611,  3};
        vecs[7] = '{1'b0, 1'b0, 32'h44, 32'h0,        4'h0, 3, 32'h12A55611,  5};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk) rst = 1'b1;

        // Table-driven single-port accesses
        foreach (vecs[i]) begin
            fixed_stall = vecs[i].stall;
            do_access(vecs[i].port_d, vecs[i].wr, vecs[i].addr, vecs[i].wdata,
                      vecs[i].wmask, 1'b1, rd, lat);
            check($sformatf("vec%0d_lat", i), lat, vecs[i].exp_lat);
            if (!vecs[i].wr) check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
        end

        // Simultaneous demand after reset: D first, then strict alternation,
        // one memory strobe every 3 cycles.
        do_reset();
        fixed_stall = 0;
        base = mon_q.size();
        fork
            begin
                logic [31:0] r;
                int          l;
                for (int k = 0; k < 4; k++) begin
                    do_access(1'b0, 1'b0, 32'h80 + 32'(4 * k), 32'h0, 4'h0, 1'b0, r, l);
                    check($sformatf("alt_i%0d_rdata", k), r, init_word(32 + k));
                end
            end
            begin
                logic [31:0] r;
                int          l;
                for (int k = 0; k < 4; k++) begin
                    do_access(1'b1, 1'b0, 32'h100 + 32'(4 * k), 32'h0, 4'h0, 1'b0, r, l);
                    check($sformatf("alt_d%0d_rdata", k), r, init_word(64 + k));
                end
            end
        join
        check("alt_count", mon_q.size() - base, 8);
        for (int j = 0; j < 8 && base + j < mon_q.size(); j++) begin
            check($sformatf("alt%0d_owner_is_d", j),
                  {31'h0, mon_q[base + j].addr >= 32'h100}, {31'h0, (j % 2) == 0});
            if (j > 0)
                check($sformatf("alt%0d_spacing", j),
                      mon_q[base + j].cyc - mon_q[base + j - 1].cyc, 3);
        end

        // Memory stall of 4 cycles on a fetch while a load queues behind it
        fixed_stall = 4;
        base = mon_q.size();
        fork
            begin
                logic [31:0] r;
                int          l;
                do_access(1'b0, 1'b0, 32'h10, 32'h0, 4'h0, 1'b1, r, l);
                check("stall_i_lat", l, 6);
                check("stall_i_rdata", r, 32'h0000_0013);
            end
            begin
                logic [31:0] r;
                int          l;
                @(posedge clk);
                do_access(1'b1, 1'b0, 32'h100, 32'h0, 4'h0, 1'b0, r, l);
                check("stall_d_lat", l, 12);
                check("stall_d_rdata", r, init_word(64));
            end
        join
        check("stall_strobes", mon_q.size() - base, 2);
        if (mon_q.size() - base >= 2)
            check("stall_gap", mon_q[base + 1].cyc - mon_q[base].cyc, 7);

        // Fetch re-strobed with another address while busy: ignored
        fixed_stall = 3;
        base = mon_q.size();
        fork
            begin
                logic [31:0] r;
                int          l;
                do_access(1'b0, 1'b0, 32'h10, 32'h0, 4'h0, 1'b1, r, l);
                check("repulse_lat", l, 5);
                check("repulse_rdata", r, 32'h0000_0013);
            end
            begin
                repeat (3) begin
                    @(posedge clk); #1;
                end
                i_addr  = 32'h20;
                i_rstrb = 1'b1;
                @(posedge clk); #1;
                i_rstrb = 1'b0;
            end
        join
        repeat (4) @(posedge clk);
        #1;
        check("repulse_strobes", mon_q.size() - base, 1);
        if (mon_q.size() > base) check("repulse_addr", mon_q[base].addr, 32'h10);

        // Asynchronous reset while a load waits on a stalled memory
        fixed_stall = 10;
        @(posedge clk); #1;
        d_addr  = 32'h104;
        d_rstrb = 1'b1;
        @(posedge clk); #1;
        d_rstrb = 1'b0;
        @(posedge clk); #3;
        check("midrst_busy_before", {31'h0, d_rbusy}, 32'h1);
        rst = 1'b0;
        #1;
        check_all_zero("midrst");
        @(negedge clk) rst = 1'b1;
        base = mon_q.size();
        repeat (5) @(posedge clk);
        #1;
        check("midrst_no_strobe", mon_q.size() - base, 0);
        check("midrst_idle_busy", {29'h0, i_rbusy, d_rbusy, d_wbusy}, 32'h0);
        fixed_stall = 0;
        do_access(1'b1, 1'b0, 32'h104, 32'h0, 4'h0, 1'b1, rd, lat);
        check("midrst_after_lat", lat, 2);
        check("midrst_after_rdata", rd, init_word(65));

        // Randomised traffic on both ports with random memory stalls.
        // Fetches target a region the data port never writes; data-port
        // results follow a plain array of the data region in program order.
        rand_stall = 1'b1;
        for (int k = 64; k < 128; k++) dmodel[k] = init_word(k);
        fork
            begin
                logic [31:0] r;
                int          l;
                int          idx;
                repeat (60) begin
                    repeat ($urandom_range(0, 3)) @(posedge clk);
                    idx = int'($urandom_range(32, 63));
                    do_access(1'b0, 1'b0, 32'(idx * 4), 32'h0, 4'h0, 1'b0, r, l);
                    check("rnd_i_rdata", r, init_word(idx));
                    check("rnd_i_lat_bound", {31'h0, l <= 11}, 32'h1);
                end
            end
            begin
                logic [31:0] r;
                logic [31:0] wd;
                logic [3:0]  wm;
                int          l;
                int          idx;
                bit          wr;
                repeat (60) begin
                    repeat ($urandom_range(0, 3)) @(posedge clk);
                    idx = int'($urandom_range(64, 127));
                    wr  = 1'($urandom_range(0, 1));
                    wd  = $urandom;
                    wm  = 4'($urandom_range(1, 15));
                    do_access(1'b1, wr, 32'(idx * 4), wd, wm, 1'b0, r, l);
                    if (wr) begin
                        for (int b = 0; b < 4; b++)
                            if (wm[b]) dmodel[idx][8*b +: 8] = wd[8*b +: 8];
                    end else begin
                        check("rnd_d_rdata", r, dmodel[idx]);
                    end
                    check("rnd_d_lat_bound", {31'h0, l <= 11}, 32'h1);
                end
            end
        join

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one `ram` instance between the rv32i instruction port (read-only) and data port (read/write), replacing the split rom/ram pair in the SoC top.
- Buffers one request per requester and serialises them onto the single memory port.
- Returns read data and busy status to the requester that owns each access.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width; wmask width is DATA_W/8

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- i_addr  in  ADDR_W  instruction fetch address
- i_rstrb  in  1  fetch strobe, one-cycle pulse
- i_rdata  out  DATA_W  fetch data
- i_rbusy  out  1  fetch in progress
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_wmask  in  DATA_W/8  byte-enable mask
- d_wstrb  in  1  store strobe, one-cycle pulse
- d_rstrb  in  1  load strobe, one-cycle pulse
- d_rdata  out  DATA_W  load data
- d_rbusy  out  1  load in progress
- d_wbusy  out  1  store in progress
- m_addr  out  ADDR_W  memory address
- m_wdata  out  DATA_W  memory write data
- m_wmask  out  DATA_W/8  memory byte mask
- m_rstrb  out  1  memory read strobe
- m_wstrb  out  1  memory write strobe
- m_rdata  in  DATA_W  memory read data
- m_rbusy  in  1  memory read busy
- m_wbusy  in  1  memory write busy

Behaviour:
- Memory protocol: strobe is a one-cycle pulse with addr/wdata/wmask valid in the same cycle. Busy is sampled from the cycle after the strobe onward. The access completes in the first such cycle with busy low; m_rdata is valid in that completion cycle.
- Pending slots: one per requester. Each holds addr, wdata, wmask and kind (R/W).
  - A strobe loads the slot at the clock edge.
  - A strobe arriving while that requester is already busy is a protocol violation: it is ignored and the slot is unchanged.
  - d_wstrb and d_rstrb in the same cycle: treated as a write.
- States:
  - IDLE: no access in flight.
  - ISSUE: the m_* strobe is driven from the selected slot for exactly one cycle.
  - WAIT: busy is polled.
- Transitions:
  - IDLE -> ISSUE when any slot is pending.
  - ISSUE -> WAIT unconditionally.
  - WAIT -> IDLE on completion; the owner's slot is cleared in the same edge.
- Arbitration on entering ISSUE:
  - Only one slot pending: that slot is selected.
  - Both pending: D wins, unless the last completed access was D, in which case I wins (alternating, so neither port starves).
  - The grant is latched for the whole access.
- Latency: strobe at cycle T, idle arbiter → m_*strb at T+1. With zero-wait memory, completion at T+2.
- Requester busy:
  - i_rbusy / d_rbusy / d_wbusy rise at T+1, and stay high while the slot is pending or in flight.
  - Each falls in the owner's completion cycle, combinational from m_*busy low.
  - Only the busy matching the access kind is driven.
- Read data: i_rdata / d_rdata are registered from m_rdata at completion and held until that port's next read completes.
- m_* outputs: addr/wdata/wmask hold the granted slot during ISSUE/WAIT and are 0 in IDLE. Strobes are high only in ISSUE.
- Back-to-back: a slot reloaded in the completion cycle is not possible, because busy was high. Its next strobe lands in IDLE at the earliest, and the minimum spacing per port is 3 cycles.
- Reset (rst low, any time, including mid-access):
  - State goes to IDLE, both slots clear, and the last-grant marker is set to I, so D wins the first tie.
  - All outputs are 0.
  - An in-flight memory access is abandoned; the memory itself is reset by the same rst.

Decomposition:
- Shared package holds:
  - the state encoding (IDLE/ISSUE/WAIT)
  - the grant encoding (GNT_I/GNT_D)
  - the access-kind encoding (RD/WR)
- One natural sub-module: `mem_req_slot`. It holds one pending request and is instantiated twice.

Test Plan:
- Fetch only: i_rstrb at T with addr 0x10 and the memory word = 0x00000013 -> m_rstrb at T+1 with m_addr 0x10; i_rbusy high at T+1, low at T+2 with i_rdata = 0x00000013.
- Store then load: d_wstrb with addr 0x40, wdata 0xDEADBEEF, mask 0xF; then d_rstrb with addr 0x40 -> d_rdata = 0xDEADBEEF. A partial store with mask 0x3 and wdata 0x0000CAFE on top of it then reads back 0xDEADCAFE.
- Simultaneous i_rstrb and d_rstrb after reset -> D issued first and I issued 3 cycles later. Repeated simultaneous pairs alternate I/D.
- Memory stalls m_rbusy for 4 cycles -> owner busy stays high throughout, the other port's pending request waits, and no second m strobe appears until completion.
- rst asserted in WAIT with a D load in flight -> all outputs 0 immediately and asynchronously. After release, the arbiter returns to IDLE with no spurious m strobe.
- i_rstrb re-pulsed while i_rbusy is high with a different address -> ignored; the original address completes and no extra access is issued.
